// File: rtl/fft_out_serializer_pkg.sv
// Shared FFT types and helpers.
// Imported by the FFT output serializer and later IFFT blocks.
package fft_out_serializer_pkg;

    localparam int CP_W = 16;

    typedef struct packed {
        logic signed [CP_W-1:0] r;
        logic signed [CP_W-1:0] i;
    } complex_product_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } ser_state_t;

    // Reverse the low nbits of idx; nbits must not exceed 32.
    function automatic int fft_bitrev(input int idx, input int nbits);
        int r;
        r = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < nbits) begin
                r = (r << 1) | ((idx >> b) & 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_serializer.sv
// Ping-pong buffered re-order and pair streamer for FFT results.
// Captures a full vector per strobe, emits (X[k], X[k+N/2]) pairs.
module fft_out_serializer
    import fft_out_serializer_pkg::*;
#(
    parameter int N           = 8,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  complex_product_t [N-1:0] in_frame,
    output logic                     in_ready,
    output logic                     overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output complex_product_t         data_0,
    output complex_product_t         data_1,
    output logic [$clog2(N)-2:0]     out_index,
    output logic                     out_last
);

    localparam int LW   = $clog2(N);
    localparam int KW   = LW - 1;
    localparam int HALF = N / 2;
    localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

    ser_state_t       state;
    complex_product_t frame_buf [2][N];
    complex_product_t src [N];
    complex_product_t pair_lo;
    complex_product_t pair_hi;

    logic [1:0]    count;
    logic [1:0]    count_n;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          sel;
    logic          cap;
    logic          fire;
    logic          drain;
    logic [KW-1:0] k_n;
    logic [LW-1:0] m_lo;
    logic [LW-1:0] m_hi;
    logic [LW-1:0] idx_lo;
    logic [LW-1:0] idx_hi;

    always_comb begin
        cap     = in_valid && in_ready;
        fire    = out_valid && out_ready;
        drain   = fire && out_last;
        count_n = count + {1'b0, cap} - {1'b0, drain};
        sel     = rd_ptr ^ drain;
        k_n     = '0;
        if (state == ST_STREAM && !drain) begin
            k_n = out_index + 1'b1;
        end
        m_lo = {1'b0, k_n};
        m_hi = {1'b1, k_n};
        idx_lo = m_lo;
        idx_hi = m_hi;
        if (BIT_REVERSE) begin
            idx_lo = LW'(fft_bitrev(int'(m_lo), LW));
            idx_hi = LW'(fft_bitrev(int'(m_hi), LW));
        end
        // A frame landing in the slot about to be read is forwarded directly.
        for (int i = 0; i < N; i++) begin
            if (cap && wr_ptr == sel) begin
                src[i] = in_frame[i];
            end else begin
                src[i] = frame_buf[sel][i];
            end
        end
        pair_lo = src[idx_lo];
        pair_hi = src[idx_hi];
    end

    always_ff @(posedge clk) begin
        if (reset && cap) begin
            for (int i = 0; i < N; i++) begin
                frame_buf[wr_ptr][i] <= in_frame[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            in_ready  <= 1'b1;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            data_0    <= '0;
            data_1    <= '0;
        end else begin
            count    <= count_n;
            in_ready <= (count_n != 2'd2);
            rd_ptr   <= sel;
            if (cap) begin
                wr_ptr <= ~wr_ptr;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state     <= ST_STREAM;
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_last  <= 1'b0;
                        data_0    <= pair_lo;
                        data_1    <= pair_hi;
                    end
                end
                ST_STREAM: begin
                    if (fire) begin
                        if (drain && count_n == '0) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            out_index <= k_n;
                            out_last  <= (k_n == K_LAST);
                            data_0    <= pair_lo;
                            data_1    <= pair_hi;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: both ordering variants on shared stimulus.
// Expected pairs are queued at issue time and popped on each handshake.
module tb_fft_out_serializer;
    import fft_out_serializer_pkg::*;

    localparam int N  = 8;
    localparam int H  = N / 2;
    localparam int LW = 3;
    localparam int KW = LW - 1;

    typedef complex_product_t [N-1:0] frame_t;

    typedef struct {
        complex_product_t d0;
        complex_product_t d1;
        int               idx;
        bit               last;
    } pair_t;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    logic   in_valid = 1'b0;
    logic   out_ready = 1'b0;
    frame_t in_frame = '0;

    logic             rdy_r, ovf_r, ov_r, last_r;
    logic             rdy_n, ovf_n, ov_n, last_n;
    complex_product_t d0_r, d1_r, d0_n, d1_n;
    logic [KW-1:0]    idx_r, idx_n;

    pair_t q_r[$];
    pair_t q_n[$];
    int    occ = 0;
    bit    exp_ovf = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    rmode = 0;
    int    rcnt = 0;

    always #5 clk = ~clk;

    fft_out_serializer #(.N(N), .BIT_REVERSE(1'b1)) u_rev (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_frame(in_frame),
        .in_ready(rdy_r), .overflow(ovf_r), .out_valid(ov_r),
        .out_ready(out_ready), .data_0(d0_r), .data_1(d1_r),
        .out_index(idx_r), .out_last(last_r)
    );

    fft_out_serializer #(.N(N), .BIT_REVERSE(1'b0)) u_nat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_frame(in_frame),
        .in_ready(rdy_n), .overflow(ovf_n), .out_valid(ov_n),
        .out_ready(out_ready), .data_0(d0_n), .data_1(d1_n),
        .out_index(idx_n), .out_last(last_n)
    );

    function automatic int tb_rev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LW; b++) begin
            if ((v & (1 << b)) != 0) r = r | (1 << (LW - 1 - b));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < N; i++) begin
            f[i].r = 16'($urandom);
            f[i].i = 16'($urandom);
        end
        return f;
    endfunction

    function automatic frame_t dir_frame();
        frame_t f;
        for (int i = 0; i < N; i++) begin
            f[i].r = 16'(100 * i);
            f[i].i = 16'(-i);
        end
        return f;
    endfunction

    // Spectrum X in natural order, then pairs (X[k], X[k+N/2]).
    task automatic push_frame(input frame_t f);
        complex_product_t xr [N];
        complex_product_t xn [N];
        pair_t e;
        for (int m = 0; m < N; m++) begin
            xr[m] = f[tb_rev(m)];
            xn[m] = f[m];
        end
        for (int k = 0; k < H; k++) begin
            e.idx  = k;
            e.last = (k == H - 1);
            e.d0 = xr[k];
            e.d1 = xr[k + H];
            q_r.push_back(e);
            e.d0 = xn[k];
            e.d1 = xn[k + H];
            q_n.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rmode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
        end else if (rmode == 2) begin
            out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            rcnt++;
        end
    endtask

    // in_ready seen by this strobe reflects occupancy after the previous edge.
    task automatic send(input frame_t f);
        in_valid = 1'b1;
        in_frame = f;
        if (occ < 2) begin
            push_frame(f);
            occ++;
        end else begin
            exp_ovf = 1'b1;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        q_r.delete();
        q_n.delete();
        occ = 0;
        exp_ovf = 1'b0;
        in_valid = 1'b1;
        in_frame = rand_frame();
        repeat (n) step();
        in_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        if (rmode == 0) out_ready = 1'b1;
        while ((q_r.size() != 0 || q_n.size() != 0) && n < 400) begin
            step();
            n++;
        end
        chk("drain_in_budget", 32'(n < 400), 32'(1));
        q_r.delete();
        q_n.delete();
    endtask

    pair_t            e_m;
    bit               pv = 1'b0;
    bit               pr = 1'b0;
    complex_product_t p0, p1;
    logic [KW-1:0]    pi;

    always @(negedge clk) begin
        if (!reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(ov_r), 32'(1));
                chk("hold_d0", 32'(d0_r), 32'(p0));
                chk("hold_d1", 32'(d1_r), 32'(p1));
                chk("hold_index", 32'(idx_r), 32'(pi));
            end
            if (ov_r && out_ready) begin
                if (q_r.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rev_pair_unexpected actual=%0h required=none", d0_r);
                end else begin
                    e_m = q_r.pop_front();
                    chk("rev_d0", 32'(d0_r), 32'(e_m.d0));
                    chk("rev_d1", 32'(d1_r), 32'(e_m.d1));
                    chk("rev_index", 32'(idx_r), 32'(e_m.idx));
                    chk("rev_last", 32'(last_r), 32'(e_m.last));
                    if (e_m.last) occ--;
                end
            end
            if (ov_n && out_ready) begin
                if (q_n.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL nat_pair_unexpected actual=%0h required=none", d0_n);
                end else begin
                    e_m = q_n.pop_front();
                    chk("nat_d0", 32'(d0_n), 32'(e_m.d0));
                    chk("nat_d1", 32'(d1_n), 32'(e_m.d1));
                    chk("nat_index", 32'(idx_n), 32'(e_m.idx));
                    chk("nat_last", 32'(last_n), 32'(e_m.last));
                end
            end
            pv = ov_r;
            pr = out_ready;
            p0 = d0_r;
            p1 = d1_r;
            pi = idx_r;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        int     n;

        do_reset(3);
        chk("rst_out_valid", 32'(ov_r), 32'(0));
        chk("rst_in_ready", 32'(rdy_r), 32'(1));
        chk("rst_overflow", 32'(ovf_r), 32'(0));
        chk("rst_index", 32'(idx_r), 32'(0));
        chk("rst_last", 32'(last_r), 32'(0));
        chk("rst_d0", 32'(d0_r), 32'(0));
        chk("rst_d1", 32'(d1_r), 32'(0));
        chk("rst_nat_valid", 32'(ov_n), 32'(0));

        // Single directed frame, latency and known values.
        out_ready = 1'b1;
        send(dir_frame());
        chk("lat_edge1_valid", 32'(ov_r), 32'(0));
        step();
        chk("lat_edge2_valid", 32'(ov_r), 32'(1));
        chk("k0_rev_d0_r", 32'(d0_r.r), 32'(0));
        chk("k0_rev_d1_r", 32'(d1_r.r), 32'(100));
        chk("k0_nat_d1_r", 32'(d1_n.r), 32'(400));
        wait_drain();

        // Back-pressure pattern 1,0,0,1.
        rmode = 2;
        rcnt = 0;
        send(dir_frame());
        wait_drain();
        rmode = 0;

        // Burst of three strobes with the consumer stalled.
        out_ready = 1'b0;
        repeat (3) send(rand_frame());
        chk("burst_overflow", 32'(ovf_r), 32'(1));
        chk("burst_in_ready", 32'(rdy_r), 32'(0));
        out_ready = 1'b1;
        for (int c = 0; c < 2 * H; c++) begin
            chk("burst_no_gap", 32'(ov_r), 32'(1));
            step();
        end
        chk("burst_idle_after", 32'(ov_r), 32'(0));
        wait_drain();

        // Strobe on the handshake of the final pair of a full buffer.
        do_reset(1);
        out_ready = 1'b0;
        send(rand_frame());
        send(rand_frame());
        out_ready = 1'b1;
        repeat (3) step();
        chk("coll_pre_index", 32'(idx_r), 32'(H - 1));
        send(rand_frame());
        chk("coll_overflow", 32'(ovf_r), 32'(1));
        chk("coll_in_ready", 32'(rdy_r), 32'(1));
        chk("coll_valid", 32'(ov_r), 32'(1));
        chk("coll_index", 32'(idx_r), 32'(0));
        wait_drain();

        // Reset mid-stream while overflow is still set.
        out_ready = 1'b1;
        send(rand_frame());
        n = 0;
        while (!(ov_r && idx_r == 2'd2) && n < 20) begin
            step();
            n++;
        end
        chk("mid_reached_k2", 32'(n < 20), 32'(1));
        do_reset(1);
        chk("mid_rst_valid", 32'(ov_r), 32'(0));
        chk("mid_rst_in_ready", 32'(rdy_r), 32'(1));
        chk("mid_rst_overflow", 32'(ovf_r), 32'(0));
        out_ready = 1'b1;
        send(dir_frame());
        wait_drain();

        // Randomized traffic with random consumer stalls.
        do_reset(2);
        rmode = 1;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 4)) step();
            f = rand_frame();
            send(f);
        end
        wait_drain();
        chk("rand_overflow_rev", 32'(ovf_r), 32'(exp_ovf));
        chk("rand_overflow_nat", 32'(ovf_n), 32'(exp_ovf));
        rmode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Output-side companion of `fft_N_rad2`. It accepts the parallel result vector (`fft_out[N-1:0]`) on the cycle the FFT pulses `out_valid`, and re-orders it from bit-reversed to natural frequency order. It then streams the result two samples per cycle, using the same `data_0`/`data_1` pairing the FFT consumes on its input. A two-frame ping-pong buffer absorbs back-pressure from the downstream consumer (IFFT, equalizer, or capture logic).

## Interface
- `N`, default 8: FFT size. Power of two, ≥4. Must equal the upstream `fft_N_rad2` N.
- `BIT_REVERSE`, default 1: 1 means the input vector is bit-reversed and is re-ordered to natural order; 0 means pass-through order.
- `clk`, input, 1: sole clock; all logic on posedge.
- `reset`, input, 1: synchronous, active-low; sampled on posedge `clk`.
- `in_valid`, input, 1: single-cycle frame strobe; connect to FFT `out_valid`.
- `in_frame`, input, `complex_product_t [N-1:0]`: FFT result vector; connect to `fft_out`.
- `in_ready`, output, 1: a buffer slot is free (registered).
- `overflow`, output, 1: sticky; set when a frame arrives with `in_ready`=0.
- `out_valid`, output, 1: `data_0`/`data_1` hold a valid pair.
- `out_ready`, input, 1: downstream accepts the pair this cycle.
- `data_0`, output, `complex_product_t`: X[k].
- `data_1`, output, `complex_product_t`: X[k+N/2].
- `out_index`, output, `$clog2(N)-1` bits: pair index k, 0..N/2-1.
- `out_last`, output, 1: high with pair k=N/2-1.

## Operation
- **Frame capture.** `in_valid && in_ready` writes `in_frame` whole into the slot at `wr_ptr`. `wr_ptr` toggles and `count` increments.
- **Dropped frames.** `in_valid && !in_ready` drops the frame, sets `overflow`, and leaves the buffers untouched.
- **Mapping.** X[m] = slot[bitrev(m)] when BIT_REVERSE=1, otherwise slot[m]. bitrev acts on `$clog2(N)` bits.
- **Output FSM.**
  - IDLE: `out_valid`=0. Moves to STREAM on the edge after `count` becomes non-zero.
  - STREAM: presents pair k from slot `rd_ptr`. On `out_valid && out_ready`:
    - k<N/2-1: k increments.
    - k=N/2-1: k returns to 0, `rd_ptr` toggles, `count` decrements. The FSM stays in STREAM with no bubble if the other slot is full, otherwise returns to IDLE.
- **Stall.** While `out_valid && !out_ready`, `data_0`, `data_1`, `out_index` and `out_last` are held stable.
- **`in_ready`.** Registered as (`count` != 2) from the post-update count. A frame arriving in the same cycle that the last pair drains a full buffer is therefore dropped: `overflow` is set and no combinational ready path exists.
- **Simultaneous capture and drain** with `count`=1: the capture and the decrement net to `count`=1, and streaming continues uninterrupted.
- **Arithmetic.** None. Samples are moved bit-exact with no width change.
- **Reset** (applies mid-frame too): `count`=0, `wr_ptr`=`rd_ptr`=0, k=0, state IDLE, `out_valid`=0, `out_last`=0, `out_index`=0, `data_0`=`data_1`=0, `overflow`=0, `in_ready`=1. Buffer contents are don't-care. A frame presented during reset is ignored.

## Timing
- **Latency.** A frame captured at edge E gives `out_valid`=1 with pair 0 in the cycle after E+1, i.e. 2 edges from the strobe to the first pair.
- **Throughput.** With `out_ready` held at 1, a frame takes exactly N/2 consecutive valid cycles. Consecutive buffered frames stream back-to-back.
- **Overflow bound.** Upstream may issue at most one frame per N/2 cycles on average. Bursts of 2 frames are absorbed; a third frame before any drain completes overflows.
- **Registered outputs.** All outputs come from flops; there is no input-to-output combinational path.

## Structure
- **Shared package.**
  - Reuse `complex_product_t` from `verilog/headers.svh`.
  - Add function `fft_bitrev(idx, nbits)` there, so the FFT and any later IFFT share it.
- **Buffer.** The ping-pong store is `complex_product_t buf [2][N]`, inline.
- **Sub-modules.** None needed; a single module of roughly 150–250 lines.

## Test plan
All cases use N=8 and BIT_REVERSE=1 unless stated. in[i] means `in_frame[i]` = {r=100·i, i=−i}.
- **Single frame, `out_ready`=1.** One strobe of in[i] gives 4 consecutive pairs:
  - k=0: (0, 100)
  - k=1: (400, 500)
  - k=2: (200, 300)
  - k=3: (600, 700), with `out_last` high
  
  Imaginary parts are the negated index. `out_valid` is first seen 2 edges after the strobe.
- **BIT_REVERSE=0, same frame.** Pairs are (0,400), (100,500), (200,600), (300,700).
- **Back-pressure.** `out_ready` is toggled 1,0,0,1,… → each pair is held during stalls, no pair is duplicated or skipped, and `out_index` follows 0,1,2,3.
- **Burst.** Strobes on 3 consecutive cycles with `out_ready`=0:
  - Frames 1 and 2 are captured; frame 3 is dropped and `overflow`=1.
  - After `out_ready`=1, 8 pairs (two frames) stream with no gap.
- **Drain-edge collision.** Two frames are buffered, and a strobe coincides with the handshake of the final pair → frame dropped, `overflow`=1, `count` goes to 1, and the second frame streams.
- **Reset mid-stream.** `reset`=0 at pair k=2 → the next cycle shows `out_valid`=0, `in_ready`=1, `overflow`=0. A subsequent single frame streams from k=0.
